// File: rtl/cc_pkg.sv
// Shared constants and types for the cache controller refill path.
// AXI encodings used for line refills and the miss-request FSM state type.
package cc_pkg;

    localparam int          LINE_BEATS     = 8;
    localparam logic [1:0]  AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0]  AXI_SIZE_8B    = 3'b011;
    localparam logic [3:0]  AXI_ARLEN_LINE = 4'(LINE_BEATS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        AR_REQ = 1'b1
    } miss_ctrl_state_t;

    // Critical-word-first: the burst starts at the 8-byte beat holding the missing word.
    function automatic logic [31:0] beat_base(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/cc_outstanding_counter.sv
// Counts refill bursts issued on AR but not yet closed by an R-channel last beat.
// Simultaneous issue and completion leave the count unchanged; the count saturates at 0 and MAX.
module cc_outstanding_counter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_count;

    // A stray rlast with nothing in flight must not wrap the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc_i && !dec_i && (r_count != MAX_CNT)) begin
            r_count <= r_count + CNT_W'(1);
        end else if (dec_i && !inc_i && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/cc_miss_request_ctrl.sv
// Accepts one cache miss at a time, pushes its address to the fill FIFO and issues a WRAP line burst on AR.
// Accept is combinational in IDLE; arvalid follows one cycle later; FIFO-full or a full outstanding count holds the miss.
module cc_miss_request_ctrl
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_req_i,
    input  logic [31:0]      miss_addr_i,
    output logic             miss_ack_o,
    input  logic             miss_addr_fifo_full_i,
    output logic             miss_addr_fifo_wren_o,
    output logic [31:0]      miss_addr_fifo_wdata_o,
    output logic             mem_arvalid_o,
    input  logic             mem_arready_i,
    output logic [31:0]      mem_araddr_o,
    output logic [3:0]       mem_arlen_o,
    output logic [2:0]       mem_arsize_o,
    output logic [1:0]       mem_arburst_o,
    input  logic             mem_rvalid_i,
    input  logic             mem_rready_i,
    input  logic             mem_rlast_i,
    output logic [CNT_W-1:0] outstanding_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    miss_ctrl_state_t r_state;
    logic             r_arvalid;
    logic [31:0]      r_araddr;
    logic [CNT_W-1:0] w_outstanding;
    logic             w_accept;
    logic             w_ar_hs;
    logic             w_burst_done;

    // Gating on the registered count is safe: only one AR can be pending at a time.
    assign w_accept     = (r_state == IDLE) && miss_req_i && !miss_addr_fifo_full_i
                          && (w_outstanding < MAX_CNT);
    assign w_ar_hs      = r_arvalid && mem_arready_i;
    assign w_burst_done = mem_rvalid_i && mem_rready_i && mem_rlast_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= AR_REQ;
                        r_arvalid <= 1'b1;
                        r_araddr  <= beat_base(miss_addr_i);
                    end
                end
                AR_REQ: begin
                    if (w_ar_hs) begin
                        r_state   <= IDLE;
                        r_arvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    cc_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_outstanding (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (w_ar_hs),
        .dec_i   (w_burst_done),
        .count_o (w_outstanding)
    );

    // The FIFO push happens in the accept cycle, ahead of AR, so the fill unit never sees data before its address.
    assign miss_ack_o             = w_accept;
    assign miss_addr_fifo_wren_o  = w_accept;
    assign miss_addr_fifo_wdata_o = miss_addr_i;

    assign mem_arvalid_o = r_arvalid;
    assign mem_araddr_o  = r_araddr;
    assign mem_arlen_o   = AXI_ARLEN_LINE;
    assign mem_arsize_o  = AXI_SIZE_8B;
    assign mem_arburst_o = AXI_BURST_WRAP;
    assign outstanding_o = w_outstanding;

endmodule

// File: tb/tb_cc_miss_request_ctrl.sv
// Directed bench for the miss request controller: stimulus pushes expected FIFO/AR values,
// a negedge monitor pops and compares them whenever the DUT acks or completes an AR handshake.
module tb_cc_miss_request_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req_i;
    logic [31:0] miss_addr_i;
    logic        miss_ack_o;
    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_rvalid_i;
    logic        mem_rready_i;
    logic        mem_rlast_i;
    logic [2:0]  outstanding_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] ack_q[$];
    logic [31:0] ar_q[$];

    always #5 clk = ~clk;

    cc_miss_request_ctrl #(.MAX_OUTSTANDING(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_req_i             (miss_req_i),
        .miss_addr_i            (miss_addr_i),
        .miss_ack_o             (miss_ack_o),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_arready_i          (mem_arready_i),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_i           (mem_rready_i),
        .mem_rlast_i            (mem_rlast_i),
        .outstanding_o          (outstanding_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an accept or an AR handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (miss_ack_o || miss_addr_fifo_wren_o) begin
                chk("wren_eq_ack", 32'(miss_addr_fifo_wren_o), 32'(miss_ack_o));
                if (ack_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ack_unexpected: got ack for 0x%08h want none", miss_addr_fifo_wdata_o);
                end else begin
                    chk("fifo_wdata", miss_addr_fifo_wdata_o, ack_q.pop_front());
                end
            end
            if (mem_arvalid_o && mem_arready_i) begin
                if (ar_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ar_unexpected: got araddr 0x%08h want none", mem_araddr_o);
                end else begin
                    chk("araddr", mem_araddr_o, ar_q.pop_front());
                end
                chk("arlen", 32'(mem_arlen_o), 32'd7);
                chk("arsize", 32'(mem_arsize_o), 32'd3);
                chk("arburst", 32'(mem_arburst_o), 32'd2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] a, input logic [31:0] exp_ar);
        ack_q.push_back(a);
        ar_q.push_back(exp_ar);
        miss_req_i  = 1'b1;
        miss_addr_i = a;
    endtask

    task automatic wait_ack(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (miss_ack_o) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (got) begin
            chk("arvalid_low_in_ack_cycle", 32'(mem_arvalid_o), 32'd0);
            step();
        end else begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ack want ack within %0d cycles", bound);
        end
    endtask

    // Holds arready low for 'delay' cycles (miss_req_i still held), then handshakes.
    task automatic finish_ar(input int delay, input bit rlast_hs, input logic [31:0] exp_ar);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("arvalid_held", 32'(mem_arvalid_o), 32'd1);
            chk("araddr_stable", mem_araddr_o, exp_ar);
            chk("no_ack_in_ar_req", 32'(miss_ack_o), 32'd0);
            step();
        end
        miss_req_i    = 1'b0;
        mem_arready_i = 1'b1;
        if (rlast_hs) begin
            mem_rvalid_i = 1'b1;
            mem_rready_i = 1'b1;
            mem_rlast_i  = 1'b1;
        end
        @(negedge clk);
        chk("arvalid_at_hs", 32'(mem_arvalid_o), 32'd1);
        step();
        mem_arready_i = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rready_i  = 1'b0;
        mem_rlast_i   = 1'b0;
    endtask

    task automatic pulse_rlast();
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        mem_rlast_i  = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i  = 1'b0;
    endtask

    task automatic chk_cnt(input string nm, input int exp);
        @(negedge clk);
        chk(nm, 32'(outstanding_o), 32'(exp));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n                 = 1'b0;
        miss_req_i            = 1'b0;
        miss_addr_i           = '0;
        miss_addr_fifo_full_i = 1'b0;
        mem_arready_i         = 1'b0;
        mem_rvalid_i          = 1'b0;
        mem_rready_i          = 1'b0;
        mem_rlast_i           = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_ack", 32'(miss_ack_o), 32'd0);
        chk("rst_wren", 32'(miss_addr_fifo_wren_o), 32'd0);
        chk("rst_arvalid", 32'(mem_arvalid_o), 32'd0);
        chk("rst_araddr", mem_araddr_o, 32'd0);
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single miss, immediate arready.
        start_miss(32'h0000_1A48, 32'h0000_1A48);
        wait_ack(4);
        finish_ar(0, 1'b0, 32'h0000_1A48);
        chk_cnt("cnt_after_1", 1);

        // arready stalled for 5 cycles with the miss still held.
        start_miss(32'h0000_2F5D, 32'h0000_2F58);
        wait_ack(4);
        finish_ar(5, 1'b0, 32'h0000_2F58);
        chk_cnt("cnt_after_2", 2);

        // Fill up to the outstanding limit.
        start_miss(32'h8000_0007, 32'h8000_0000);
        wait_ack(4);
        finish_ar(0, 1'b0, 32'h8000_0000);
        start_miss(32'hFFFF_FFFC, 32'hFFFF_FFF8);
        wait_ack(4);
        finish_ar(1, 1'b0, 32'hFFFF_FFF8);
        chk_cnt("cnt_at_max", 4);

        // Fifth miss blocked until a burst completes.
        start_miss(32'h1234_567B, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("max_no_ack", 32'(miss_ack_o), 32'd0);
            chk("max_no_wren", 32'(miss_addr_fifo_wren_o), 32'd0);
            chk("max_no_arvalid", 32'(mem_arvalid_o), 32'd0);
            step();
        end
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        mem_rlast_i  = 1'b1;
        @(negedge clk);
        chk("no_ack_in_rlast_cycle", 32'(miss_ack_o), 32'd0);
        step();
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i  = 1'b0;
        wait_ack(1);
        finish_ar(0, 1'b0, 32'h1234_5678);
        chk_cnt("cnt_back_at_max", 4);

        pulse_rlast();
        pulse_rlast();
        chk_cnt("cnt_drained_2", 2);

        // FIFO full holds the miss; a dropped request issues nothing.
        miss_addr_fifo_full_i = 1'b1;
        start_miss(32'h0000_0C3E, 32'h0000_0C38);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_no_ack", 32'(miss_ack_o), 32'd0);
            chk("full_no_wren", 32'(miss_addr_fifo_wren_o), 32'd0);
            chk("full_no_arvalid", 32'(mem_arvalid_o), 32'd0);
            step();
        end
        miss_req_i            = 1'b0;
        miss_addr_fifo_full_i = 1'b0;
        @(negedge clk);
        chk("dropped_no_ack", 32'(miss_ack_o), 32'd0);
        step();
        @(negedge clk);
        chk("dropped_no_arvalid", 32'(mem_arvalid_o), 32'd0);
        step();
        miss_addr_fifo_full_i = 1'b1;
        miss_req_i            = 1'b1;
        @(negedge clk);
        chk("full_again_no_ack", 32'(miss_ack_o), 32'd0);
        step();
        miss_addr_fifo_full_i = 1'b0;
        wait_ack(1);

        // AR handshake and rlast in the same cycle at count 2.
        finish_ar(0, 1'b1, 32'h0000_0C38);
        chk_cnt("cnt_hs_and_rlast", 2);

        // Reset while an AR is pending.
        start_miss(32'h0000_4444, 32'h0000_4440);
        wait_ack(4);
        @(negedge clk);
        chk("arvalid_before_rst", 32'(mem_arvalid_o), 32'd1);
        step();
        miss_req_i = 1'b0;
        rst_n      = 1'b0;
        step();
        rst_n = 1'b1;
        ar_q.delete();
        @(negedge clk);
        chk("rst_mid_arvalid", 32'(mem_arvalid_o), 32'd0);
        chk("rst_mid_outstanding", 32'(outstanding_o), 32'd0);
        step();

        // Stray rlast with nothing outstanding must not wrap the count.
        pulse_rlast();
        chk_cnt("cnt_rlast_at_zero", 0);

        start_miss(32'h0000_0008, 32'h0000_0008);
        wait_ack(4);
        finish_ar(1, 1'b0, 32'h0000_0008);
        chk_cnt("cnt_after_reset_miss", 1);

        repeat (2) step();
        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
        chk("ar_q_drained", 32'(ar_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
